// File: rtl/duc_cic_interp.sv
// CIC interpolator front end for the transmit path: N comb stages at the low rate,
// zero-stuffing by R, N integrators at the clk rate, then a truncated signed output.
module duc_cic_interp #(
  parameter int DIN_W  = 16,
  parameter int N      = 3,
  parameter int R_LOG2 = 5,
  parameter int DOUT_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  output logic              underrun
);

  localparam int IW      = DIN_W + N*R_LOG2;
  localparam int OUT_MSB = DIN_W + (N-1)*R_LOG2 - 1;
  // Phase one before the last, so the registered decode is high while ph_cnt == R-1.
  localparam logic [R_LOG2-1:0] PH_PRE = {{(R_LOG2-1){1'b1}}, 1'b0};

  logic [R_LOG2-1:0] ph_cnt_q;
  logic              din_ready_q;
  logic              stb1_q;
  logic              stb2_q;
  logic              underrun_q;
  logic [IW-1:0]     x_q;
  logic [IW-1:0]     c_q;
  logic [IW-1:0]     u_q;
  logic [IW-1:0]     z_q [N];
  logic [IW-1:0]     i_q [N];
  logic [IW-1:0]     y   [N+1];
  logic [DOUT_W-1:0] dout_q;
  logic [N+3:0]      vld_q;
  logic [IW-1:0]     din_ext;

  assign din_ext = {{(IW-DIN_W){din[DIN_W-1]}}, din};

  // NOTE: always_comb assigns every output before any use, so no latch can be inferred.
  always_comb begin
    y[0] = x_q;
    for (int k = 0; k < N; k++) begin
      y[k+1] = y[k] - z_q[k];
    end
  end

  // NOTE: sequential state uses <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_cnt_q    <= '0;
      din_ready_q <= 1'b0;
      stb1_q      <= 1'b0;
      stb2_q      <= 1'b0;
      underrun_q  <= 1'b0;
      x_q         <= '0;
      c_q         <= '0;
      u_q         <= '0;
      dout_q      <= '0;
      vld_q       <= '0;
      // NOTE: the delay/integrator arrays are cleared too; stale state would leak into dout.
      for (int k = 0; k < N; k++) begin
        z_q[k] <= '0;
        i_q[k] <= '0;
      end
    end else begin
      ph_cnt_q    <= ph_cnt_q + 1'b1;
      din_ready_q <= (ph_cnt_q == PH_PRE);
      stb1_q      <= din_ready_q;
      stb2_q      <= stb1_q;

      // A starved slot still feeds the comb, with a zero sample.
      if (din_ready_q) begin
        x_q <= din_valid ? din_ext : '0;
        if (!din_valid) underrun_q <= 1'b1;
      end

      if (stb1_q) begin
        for (int k = 0; k < N; k++) begin
          z_q[k] <= y[k];
        end
        c_q <= y[N];
      end

      u_q    <= stb2_q ? c_q : '0;
      i_q[0] <= i_q[0] + u_q;
      for (int k = 1; k < N; k++) begin
        i_q[k] <= i_q[k] + i_q[k-1];
      end

      // Integrator wrap is harmless: the kept bits always hold the true filtered value.
      dout_q <= i_q[N-1][OUT_MSB -: DOUT_W];
      vld_q  <= {vld_q[N+2:0], vld_q[0] | (din_ready_q & din_valid)};
    end
  end

  assign din_ready  = din_ready_q;
  assign dout       = dout_q;
  assign dout_valid = vld_q[N+3];
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_duc_cic_interp.sv
// Self-checking bench for duc_cic_interp: directed DC/impulse/step/underrun/reset stimulus,
// scoreboard queue filled by the driver and drained by a dout monitor.
module tb_duc_cic_interp;

  localparam int DIN_W  = 16;
  localparam int N      = 3;
  localparam int R_LOG2 = 5;
  localparam int DOUT_W = 21;
  localparam int R      = 32;
  localparam int HLEN   = N*(R-1) + 1;
  localparam int LAT    = N + 3;
  localparam int SHIFT  = DIN_W + (N-1)*R_LOG2 - DOUT_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DIN_W-1:0]  din;
  logic              din_valid;
  logic              din_ready;
  logic [DOUT_W-1:0] dout;
  logic              dout_valid;
  logic              underrun;

  always #5 clk = ~clk;

  duc_cic_interp #(
    .DIN_W (DIN_W),
    .N     (N),
    .R_LOG2(R_LOG2),
    .DOUT_W(DOUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .underrun  (underrun)
  );

  int     checks = 0;
  int     errors = 0;
  int     edge_cnt;
  bit     started;
  int     hist[$];
  longint exp_q[$];
  longint h[HLEN];
  longint mon_exp;
  longint prev;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, wanted %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic longint sout();
    return longint'($signed(dout));
  endfunction

  // Reference: zero-stuffed input convolved with the triple boxcar, then truncated.
  function automatic longint model_out(input int e);
    longint acc = 0;
    for (int m = 0; m < hist.size(); m++) begin
      int n = e - LAT - R*(m+1);
      if (n >= 0 && n < HLEN) acc += longint'(hist[m]) * h[n];
    end
    return acc >>> SHIFT;
  endfunction

  // One clk: drive at the negedge, count the edge, log slot samples, check din_ready.
  task automatic tick(input int d, input bit v);
    if ((edge_cnt + 1) % R == 0) begin
      din       = DIN_W'(d);
      din_valid = v;
    end else begin
      din       = DIN_W'($urandom);
      din_valid = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    edge_cnt++;
    if (edge_cnt % R == 0) begin
      hist.push_back(v ? d : 0);
      if (v) started = 1'b1;
      if (started) begin
        for (int e = edge_cnt + LAT; e < edge_cnt + LAT + R; e++) exp_q.push_back(model_out(e));
      end
    end
    @(negedge clk);
    check("din_ready", din_ready == (edge_cnt % R == R-1), din_ready, (edge_cnt % R == R-1));
  endtask

  task automatic run(input int n, input int d, input bit v);
    repeat (n) tick(d, v);
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (exp_q.size() == 0) begin
        check("dout_sb_empty", 1'b0, sout(), 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("dout_sb", sout() == mon_exp, sout(), mon_exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    edge_cnt  = 0;
    started   = 1'b0;
    for (int n = 0; n < HLEN; n++) begin
      h[n] = 0;
      for (int a = 0; a < R; a++)
        for (int b = 0; b < R; b++)
          if (n - a - b >= 0 && n - a - b < R) h[n]++;
    end

    repeat (3) @(negedge clk);
    check("rst_din_ready", din_ready == 1'b0, din_ready, 0);
    check("rst_dout", dout == '0, sout(), 0);
    check("rst_dout_valid", dout_valid == 1'b0, dout_valid, 0);
    check("rst_underrun", underrun == 1'b0, underrun, 0);
    rst_n = 1'b1;

    // Impulse at the first slot (edge 32); response starts at edge 38.
    run(R-1, 0, 1'b1);
    run(1, 32767, 1'b1);
    run(LAT-1, 0, 1'b1);
    check("imp_pre_dout", dout == '0, sout(), 0);
    check("imp_pre_valid", dout_valid == 1'b0, dout_valid, 0);
    run(1, 0, 1'b1);
    check("imp_first_dout", sout() == 1023, sout(), 1023);
    check("imp_valid_rise", dout_valid == 1'b1, dout_valid, 1);
    run(10*R - edge_cnt, 0, 1'b1);
    check("imp_tail_zero", dout == '0, sout(), 0);

    // DC levels, each held for 13 slots (over 4*N*R clks).
    run(13*R, 1000, 1'b1);
    check("dc_1000", sout() == 32000, sout(), 32000);
    run(13*R, 32767, 1'b1);
    check("dc_max", sout() == 1048544, sout(), 1048544);
    run(13*R, -32768, 1'b1);
    check("dc_min", sout() == -1048576, sout(), -1048576);

    // Full-scale negative to positive step must rise without any wrap glitch.
    prev = sout();
    repeat (13*R) begin
      tick(1000, 1'b1);
      check("step_mono", sout() >= prev, sout(), prev);
      prev = sout();
    end
    check("step_final", sout() == 32000, sout(), 32000);

    // One starved slot while streaming DC 1000.
    check("underrun_pre", underrun == 1'b0, underrun, 0);
    run(R, 1000, 1'b0);
    check("underrun_set", underrun == 1'b1, underrun, 1);
    repeat (4*R) begin
      tick(1000, 1'b1);
      check("valid_hold", dout_valid == 1'b1, dout_valid, 1);
    end
    check("underrun_hold", underrun == 1'b1, underrun, 1);
    check("underrun_recover", sout() == 32000, sout(), 32000);

    // Asynchronous reset at an odd phase, then re-converge.
    run(13, 1000, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout", dout == '0, sout(), 0);
    check("midrst_dout_valid", dout_valid == 1'b0, dout_valid, 0);
    check("midrst_din_ready", din_ready == 1'b0, din_ready, 0);
    check("midrst_underrun", underrun == 1'b0, underrun, 0);
    exp_q.delete();
    hist.delete();
    started = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
    run(13*R, 1000, 1'b1);
    check("rerun_underrun", underrun == 1'b0, underrun, 0);
    check("rerun_dc_1000", sout() == 32000, sout(), 32000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/duc_cic_interp.md
Name: duc_cic_interp

Overview:
- CIC interpolator (digital up-converter front end), the transmit-side counterpart of the ddc CIC decimator.
- Accepts low-rate signed samples, one per R clocks, through a ready/valid handshake.
- Processing chain: N comb stages at the low rate, zero-stuffing by R, then N integrator stages at the clk rate.
- Emits one truncated signed sample per clk to the NCO/mixer/DAC path.

Parameters:
- DIN_W, 16, input sample width, signed two's complement.
- N, 3, number of comb stages and number of integrator stages.
- R_LOG2, 5, log2 of the interpolation factor; R = 32.
- DOUT_W, 21, output width. Must satisfy DOUT_W <= DIN_W+(N-1)*R_LOG2.

Ports:
- clk  input  1  sample clock (output rate).
- rst_n  input  1  asynchronous active-low reset.
- din  input  DIN_W  signed low-rate sample.
- din_valid  input  1  din holds a valid sample.
- din_ready  output  1  block takes din this cycle; high one clk in every R.
- dout  output  DOUT_W  signed interpolated sample, one per clk.
- dout_valid  output  1  dout carries filtered data.
- underrun  output  1  sticky; set when a request slot found din_valid low.

Behaviour:
- Reset is asynchronous: rst_n low forces every register to 0 at once, whether idle or mid-stream. This covers ph_cnt, comb delays, integrators, dout, dout_valid, din_ready and underrun.
- Internal width: IW = DIN_W+N*R_LOG2 (31). Every comb and integrator register is IW bits. Arithmetic is two's complement, and integrator wrap-around is allowed and required, with no saturation.
- Phase counter ph_cnt: R_LOG2 bits, free-running 0..R-1. It wraps from R-1 to 0 with no gap.
- din_ready is a registered decode, high exactly while ph_cnt==R-1. After reset release the first din_ready cycle is the R-th clk; after that it repeats every R clks.
- Accept edge T is the clk edge where din_ready is high:
  - If din_valid=1, x <= sign-extended din.
  - If din_valid=0, x <= 0 and underrun <= 1. underrun stays 1 until reset.
  - In both cases stb1 <= 1 for one cycle. din is ignored outside din_ready cycles.
- Comb: the N subtractions are a combinational chain, y0=x and yk = y(k-1) - zk.
  - On the stb1 edge (T+1): zk <= y(k-1) for every k, c_reg <= yN, and stb2 <= 1 for one cycle.
- Zero-stuff: u = c_reg while stb2 is high, otherwise 0. This gives one nonzero value per R clks.
- Integrators are registered every clk: i1 <= i1 + u and ik <= ik + i(k-1).
  - i1 first reflects the sample at T+3, and iN at T+2+N.
- Output: dout <= iN[DIN_W+(N-1)*R_LOG2-1 -: DOUT_W], which is bits [25:5] at defaults.
  - This is plain truncation with no rounding.
  - Total filter gain is R^(N-1) = 1024. After truncation the net DC gain is 2^((N-1)*R_LOG2-(DIN_W+(N-1)*R_LOG2-DOUT_W)) = 32 at defaults.
- Latency: the first contribution of a sample accepted at edge T appears on dout after edge T+N+3 (T+6 at defaults).
- dout_valid: rises together with dout for the first accepted sample, at T+N+3 counted from the first accept after reset. It stays high until reset. An underrun slot does not clear it, and it does not count as a first sample.
- Simultaneous events:
  - An underrun slot still advances the comb state, with x=0.
  - din_valid high with din_ready low is not an error and not consumed; the sample is held until the next slot.

Test Plan:
- Reset release, din_valid=1 held → din_ready high first in clk 32 after release, then every 32 clks exactly. Check 10 periods with no jitter across the ph_cnt wrap.
- Single impulse din=32767 at one accept, 0 otherwise → dout=0 before T+6, dout=1023 at T+6, dout_valid rising at T+6. Output then returns to 0 and stays 0 after the response ends (N*R clks).
- DC din=1000 continuous → after 4*N*R clks dout=32000 on every clk. DC din=32767 → 1048544. DC din=-32768 → -1048576 (0x100000).
- Step din from -32768 to 1000 mid-stream → dout moves monotonically (CIC step) from -1048576 to 32000 with no wrap glitch visible on dout, confirming integrator wrap is benign.
- din_valid forced low for one slot while streaming DC 1000 → underrun=1 from that edge and held. A transient dip shows on dout, which recovers to 32000 within N*R clks. dout_valid stays 1.
- rst_n pulsed low mid-stream at an arbitrary phase → all outputs 0 immediately. After release: din_ready timing restarts at clk 32, underrun=0, and the DC response re-converges to the same values.
